// File: rtl/audio_fifo_pkg.sv
`timescale 1ns/1ps
// Register map, STATUS/CTRL/CLEAR bit positions and the CTRL register layout
// shared by the audio FIFO top and anything that talks to it.
package audio_fifo_pkg;

    // Word addresses; 0x0..CHANNELS-1 are the per-channel HEAD registers
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_POP    = 4'h9;
    localparam logic [3:0] ADDR_CTRL   = 4'hA;
    localparam logic [3:0] ADDR_CLEAR  = 4'hB;

    // STATUS fields; level occupies bits [15:0]
    localparam int STATUS_OVF_BIT   = 18;
    localparam int STATUS_FULL_BIT  = 17;
    localparam int STATUS_EMPTY_BIT = 16;

    // CTRL fields
    localparam int CTRL_IRQ_EN_BIT  = 31;

    // CLEAR command bits
    localparam int CLEAR_OVF_BIT    = 0;
    localparam int CLEAR_FLUSH_BIT  = 1;

    typedef struct packed {
        logic        irq_en;
        logic [14:0] rsvd;
        logic [15:0] threshold;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{irq_en: 1'b0, rsvd: 15'd0, threshold: 16'd1};

endpackage

// File: rtl/audio_fifo_interface_if.sv
`timescale 1ns/1ps
// Frame input strobe plus the register bus of the audio FIFO. The master side
// is the sample source / CPU, the slave side is the FIFO block.
interface audio_fifo_interface_if #(
    parameter int DATA_W = 48
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              chipselect;
    logic [3:0]        address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       read_data;
    logic              irq;

    modport master (
        output in_data, in_ready, chipselect, address, read, write, writedata,
        input  read_data, irq
    );

    modport slave (
        input  in_data, in_ready, chipselect, address, read, write, writedata,
        output read_data, irq
    );
endinterface

// File: rtl/audio_fifo_interface_frame_fifo.sv
`timescale 1ns/1ps
// Frame FIFO: DEPTH entries of WIDTH bits. The level counter is kept apart
// from the pointers so full and empty never alias. Flush beats push and pop.
module frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] level_next
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    // Accept/refuse decisions and next pointer/level values
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pop_ok   = pop && (level_q != '0) && !flush;
        push_ok  = push && !flush && ((level_q != LVL_W'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Frame storage write at the tail
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the level counter alone decides which entries are valid.
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head       = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign level_next = level_d;

endmodule

// File: rtl/audio_fifo_interface.sv
`timescale 1ns/1ps
// Audio frame FIFO with a small register interface: per-channel head peek,
// status, pop-by-read, threshold/overflow interrupt control and clear.
module audio_fifo_interface
    import audio_fifo_pkg::*;
#(
    parameter int DATA_SIZE = 24,
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 16
) (
    input logic                   clk,
    input logic                   rst,
    audio_fifo_interface_if.slave bus
);

    localparam int FRAME_W = CHANNELS * DATA_SIZE;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic               rd_en, wr_en;
    logic               pop_req, flush_req, clr_ovf, ovf_event;
    logic               empty, full;
    logic [FRAME_W-1:0] head;
    logic [LVL_W-1:0]   level, level_next;
    logic [15:0]        thr_eff;
    ctrl_t              ctrl_q, ctrl_d;
    logic               overflow_q, overflow_d;
    logic               irq_q, irq_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               unused_wdata;

    assign rd_en     = bus.chipselect && bus.read;
    assign wr_en     = bus.chipselect && bus.write;
    assign pop_req   = rd_en && (bus.address == ADDR_POP);
    assign flush_req = wr_en && (bus.address == ADDR_CLEAR) && bus.writedata[CLEAR_FLUSH_BIT];
    assign clr_ovf   = wr_en && (bus.address == ADDR_CLEAR) && bus.writedata[CLEAR_OVF_BIT];
    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    // A push is dropped only when full and no pop frees a slot in the same cycle
    assign ovf_event = bus.in_ready && !flush_req && full && !pop_req;
    assign unused_wdata = ^bus.writedata[30:16];

    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.in_ready),
        .pop        (pop_req),
        .flush      (flush_req),
        .wr_data    (bus.in_data),
        .head       (head),
        .level      (level),
        .level_next (level_next)
    );

    // Register read mux; read_data only changes on a qualified read
    always_comb begin
        read_data_d = read_data_q;
        if (rd_en) begin
            read_data_d = '0;
            if (int'(bus.address) < CHANNELS) begin
                if (!empty) read_data_d[DATA_SIZE-1:0] = head[int'(bus.address)*DATA_SIZE +: DATA_SIZE];
            end else begin
                case (bus.address)
                    ADDR_STATUS: begin
                        read_data_d[STATUS_OVF_BIT]   = overflow_q;
                        read_data_d[STATUS_FULL_BIT]  = full;
                        read_data_d[STATUS_EMPTY_BIT] = empty;
                        read_data_d[15:0]             = 16'(level);
                    end
                    ADDR_POP:  read_data_d[0] = !empty;
                    ADDR_CTRL: read_data_d    = ctrl_q;
                    default:   read_data_d    = '0;
                endcase
            end
        end
    end

    // CTRL write, sticky overflow and interrupt condition on post-update state
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && (bus.address == ADDR_CTRL)) begin
            ctrl_d.irq_en    = bus.writedata[CTRL_IRQ_EN_BIT];
            ctrl_d.rsvd      = '0;
            ctrl_d.threshold = bus.writedata[15:0];
        end
        // A new overflow in the same cycle wins over the clear
        overflow_d = (overflow_q && !clr_ovf) || ovf_event;
        // Threshold 0 behaves as 1; values above DEPTH can never be reached
        thr_eff    = (ctrl_d.threshold == '0) ? 16'd1 : ctrl_d.threshold;
        irq_d      = ctrl_d.irq_en && ((32'(level_next) >= 32'(thr_eff)) || overflow_d);
    end

    // Control/status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= CTRL_RESET;
            overflow_q  <= 1'b0;
            irq_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            overflow_q  <= overflow_d;
            irq_q       <= irq_d;
            read_data_q <= read_data_d;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.irq       = irq_q;

endmodule

// File: tb/tb_audio_fifo_interface.sv
`timescale 1ns/1ps
// Directed bench for audio_fifo_interface with a frame scoreboard queue.
module tb_audio_fifo_interface;

    localparam int DATA_SIZE = 24;
    localparam int CHANNELS  = 2;
    localparam int DEPTH     = 16;
    localparam int FRAME_W   = DATA_SIZE * CHANNELS;

    localparam logic [3:0] A_HEAD0  = 4'h0;
    localparam logic [3:0] A_HEAD1  = 4'h1;
    localparam logic [3:0] A_HEAD2  = 4'h2;
    localparam logic [3:0] A_STATUS = 4'h8;
    localparam logic [3:0] A_POP    = 4'h9;
    localparam logic [3:0] A_CTRL   = 4'hA;
    localparam logic [3:0] A_CLEAR  = 4'hB;
    localparam logic [3:0] A_UNMAP  = 4'hC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [FRAME_W-1:0] model[$];
    logic               m_ovf = 1'b0;

    audio_fifo_interface_if #(.DATA_W(FRAME_W)) bus ();

    audio_fifo_interface #(
        .DATA_SIZE (DATA_SIZE),
        .CHANNELS  (CHANNELS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {13'b0, m_ovf, model.size() == DEPTH, model.size() == 0, 16'(model.size())};
    endfunction

    function automatic logic [31:0] ch(input logic [FRAME_W-1:0] f, input int n);
        logic [31:0] v;
        v = '0;
        v[DATA_SIZE-1:0] = f[n*DATA_SIZE +: DATA_SIZE];
        return v;
    endfunction

    // All tasks start and end #1 after a rising edge
    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = addr;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read = 1'b0;
        data = bus.read_data;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = addr; bus.writedata = wdata;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
        if (addr == A_CLEAR) begin
            if (wdata[0]) m_ovf = 1'b0;
            if (wdata[1]) model.delete();
        end
    endtask

    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        bus.in_data = {r, l}; bus.in_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_ready = 1'b0;
        if (model.size() < DEPTH) model.push_back({r, l});
        else m_ovf = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    // Peek both channels against the scoreboard head, then pop
    task automatic pop_check(input string tag);
        logic [FRAME_W-1:0] f;
        if (model.size() > 0) begin
            f = model[0];
            read_check({tag, "_head0"}, A_HEAD0, ch(f, 0));
            read_check({tag, "_head1"}, A_HEAD1, ch(f, 1));
            read_check({tag, "_pop"},   A_POP,   32'd1);
            void'(model.pop_front());
        end else begin
            read_check({tag, "_head0_empty"}, A_HEAD0, 32'd0);
            read_check({tag, "_pop_empty"},   A_POP,   32'd0);
        end
    endtask

    // POP read and in_ready in the same cycle
    task automatic push_pop(input string tag, input logic [23:0] l, input logic [23:0] r);
        logic [31:0] d;
        logic [31:0] exp;
        bus.in_data = {r, l}; bus.in_ready = 1'b1;
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = A_POP;
        @(posedge clk); #1;
        bus.in_ready = 1'b0; bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.read_data;
        exp = (model.size() > 0) ? 32'd1 : 32'd0;
        if (model.size() > 0) void'(model.pop_front());
        if (model.size() < DEPTH) model.push_back({r, l});
        else m_ovf = 1'b1;
        check(tag, d, exp);
    endtask

    // CLEAR write and in_ready in the same cycle
    task automatic push_clear(input logic [31:0] wdata, input logic [23:0] l, input logic [23:0] r);
        logic ev;
        bus.in_data = {r, l}; bus.in_ready = 1'b1;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = A_CLEAR; bus.writedata = wdata;
        @(posedge clk); #1;
        bus.in_ready = 1'b0; bus.chipselect = 1'b0; bus.write = 1'b0;
        ev = 1'b0;
        if (wdata[1]) model.delete();
        else if (model.size() < DEPTH) model.push_back({r, l});
        else ev = 1'b1;
        if (wdata[0]) m_ovf = 1'b0;
        if (ev) m_ovf = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        bus.in_data = '0; bus.in_ready = 1'b0; bus.chipselect = 1'b0;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_read_data", bus.read_data, 32'd0);
        check("reset_irq", 32'(bus.irq), 32'd0);
        rst = 1'b0;

        // Defaults: first push lands on the first edge after reset release
        push_frame(24'h000011, 24'h000022);
        push_frame(24'h000033, 24'h000044);
        push_frame(24'h000055, 24'h000066);
        read_check("status_l3", A_STATUS, exp_status());
        read_check("head0_l3", A_HEAD0, 32'h11);
        read_check("head1_l3", A_HEAD1, 32'h22);
        read_check("head2_unmapped", A_HEAD2, 32'd0);
        read_check("addr_c_unmapped", A_UNMAP, 32'd0);
        read_check("ctrl_reset", A_CTRL, 32'h0000_0001);
        pop_check("defaults_pop1");
        read_check("status_l2", A_STATUS, 32'h0000_0002);
        pop_check("defaults_pop2");
        pop_check("defaults_pop3");
        pop_check("defaults_pop_empty");

        // Overfill: 17 pushes, the 17th dropped
        for (int i = 0; i < 17; i++) push_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
        read_check("status_overflow", A_STATUS, 32'h0006_0010);
        for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_drain%0d", i));
        pop_check("ovf_pop17");
        read_check("status_ovf_empty", A_STATUS, exp_status());
        bus_write(A_CLEAR, 32'h1);
        read_check("status_ovf_cleared", A_STATUS, 32'h0001_0000);

        // Threshold interrupt
        bus_write(A_CTRL, 32'h8000_0004);
        read_check("ctrl_readback", A_CTRL, 32'h8000_0004);
        for (int i = 0; i < 3; i++) push_frame(24'h300000 + 24'(i), 24'h400000 + 24'(i));
        check("irq_below_thr", 32'(bus.irq), 32'd0);
        push_frame(24'h300003, 24'h400003);
        check("irq_at_thr", 32'(bus.irq), 32'd1);
        pop_check("irq_pop");
        check("irq_after_pop", 32'(bus.irq), 32'd0);

        // Read and write of CTRL together: read sees the old value
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
        bus.address = A_CTRL; bus.writedata = 32'h8000_0000;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        check("ctrl_rw_same_cycle", bus.read_data, 32'h8000_0004);
        check("irq_thr0_as_1", 32'(bus.irq), 32'd1);
        read_check("ctrl_after_rw", A_CTRL, 32'h8000_0000);

        // Threshold above DEPTH never fires; fill to full
        bus_write(A_CTRL, 32'h8000_0011);
        for (int i = 0; i < 13; i++) push_frame(24'h500000 + 24'(i), 24'h600000 + 24'(i));
        check("irq_thr_above_depth", 32'(bus.irq), 32'd0);
        read_check("status_full", A_STATUS, 32'h0002_0010);

        // Push and pop together while full, across pointer wrap
        for (int i = 0; i < 5; i++) push_pop($sformatf("full_pushpop%0d", i), 24'h700000 + 24'(i), 24'h800000 + 24'(i));
        read_check("status_full_pushpop", A_STATUS, 32'h0002_0010);
        for (int i = 0; i < 16; i++) pop_check($sformatf("wrap_drain%0d", i));
        read_check("status_wrap_empty", A_STATUS, exp_status());

        // Push and pop together while empty
        push_pop("empty_pushpop", 24'h0000AA, 24'h0000BB);
        read_check("status_empty_pushpop", A_STATUS, 32'h0000_0001);
        pop_check("empty_pushpop_drain");

        // Flush beats a same-cycle push
        bus_write(A_CTRL, 32'h0000_0001);
        push_frame(24'h000001, 24'h000002);
        push_frame(24'h000003, 24'h000004);
        push_clear(32'h2, 24'h000005, 24'h000006);
        read_check("status_flush_push", A_STATUS, 32'h0001_0000);

        // Overflow clear together with a new overflow keeps overflow set
        for (int i = 0; i < 17; i++) push_frame(24'h900000 + 24'(i), 24'hA00000 + 24'(i));
        push_clear(32'h1, 24'h0000CC, 24'h0000DD);
        read_check("status_clr_vs_ovf", A_STATUS, 32'h0006_0010);
        bus_write(A_CLEAR, 32'h3);
        read_check("status_clear3", A_STATUS, 32'h0001_0000);

        // Asynchronous reset mid-burst
        bus_write(A_CTRL, 32'h8000_0004);
        for (int i = 0; i < 9; i++) push_frame(24'hB00000 + 24'(i), 24'hC00000 + 24'(i));
        check("irq_before_rst", 32'(bus.irq), 32'd1);
        bus.in_data = {24'hEEEEEE, 24'hDDDDDD}; bus.in_ready = 1'b1;
        #5;
        rst = 1'b1;
        #1;
        check("async_rst_irq", 32'(bus.irq), 32'd0);
        check("async_rst_level", 32'(dut.level), 32'd0);
        check("async_rst_read_data", bus.read_data, 32'd0);
        bus.in_ready = 1'b0;
        model.delete();
        m_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        read_check("ctrl_after_rst", A_CTRL, 32'h0000_0001);
        read_check("status_after_rst", A_STATUS, exp_status());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_fifo_interface.md
AUDIO_FIFO_INTERFACE -- requirements
Module: audio_fifo_interface

Interface
REQ-001 Parameter DATA_SIZE, default 24: bits per sample per channel, range 1..32.
REQ-002 Parameter CHANNELS, default 2: channels per frame, range 1..8.
REQ-003 Parameter DEPTH, default 16: frames stored, power of two, range 2..256.
REQ-004 clk  input  1  system clock, 50 MHz; the single clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  CHANNELS*DATA_SIZE  one frame; channel n occupies bits [n*DATA_SIZE +: DATA_SIZE].
REQ-007 in_ready  input  1  one-cycle strobe that pushes in_data as one frame.
REQ-008 chipselect  input  1  slave select.
REQ-009 address  input  4  register word address.
REQ-010 read  input  1  read strobe, qualified by chipselect.
REQ-011 write  input  1  write strobe, qualified by chipselect.
REQ-012 writedata  input  32  write data.
REQ-013 read_data  output  32  registered read data.
REQ-014 irq  output  1  registered level interrupt.

Function
REQ-015 Register map: 0x0..CHANNELS-1 HEAD[n] (R); 0x8 STATUS (R); 0x9 POP (R); 0xA CTRL (R/W); 0xB CLEAR (W).
REQ-016 HEAD[n] read returns channel n of the oldest frame, zero-extended, without popping; returns 0 when empty.
REQ-017 STATUS = {13'b0, overflow[18], full[17], empty[16], level[15:0]}; level is the frame count, 0..DEPTH.
REQ-018 POP read removes the oldest frame and returns 1; when empty it returns 0 and changes nothing.
REQ-019 CTRL = {irq_en[31], 15'b0, threshold[15:0]}; a write updates both fields; a read returns the stored value.
REQ-020 A CLEAR write with writedata[0]=1 clears overflow; writedata[1]=1 flushes the FIFO (level 0, pointers equal).
REQ-021 Reads of unmapped or out-of-range addresses (HEAD n >= CHANNELS, 0xC..0xF) return 0; writes there are ignored.
REQ-022 read_data updates one cycle after the qualified read and holds its value until the next qualified read.
REQ-023 in_ready with level < DEPTH writes the frame at the tail, advances the tail, and increments level.
REQ-024 in_ready with level = DEPTH and no same-cycle pop drops the frame and sets sticky overflow.
REQ-025 Same-cycle push and pop when full: both are accepted, level is unchanged, and overflow is not set.
REQ-026 Same-cycle push and pop when empty: the push is accepted, the pop returns 0, and level becomes 1.
REQ-027 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; level is held separately, so full and empty are unambiguous.
REQ-028 Same-cycle flush and push: the flush takes priority and the pushed frame is discarded.
REQ-029 Same-cycle overflow clear and new overflow event: overflow stays set.
REQ-030 A stored threshold of 0 is treated as 1; thresholds above DEPTH never trigger.
REQ-031 irq is registered: next irq = irq_en AND ((level >= threshold) OR overflow), using post-update level.
REQ-032 irq falls one cycle after the condition clears (pops, flush, clear, or irq_en=0).
REQ-033 Simultaneous read and write strobes perform both; the read sees pre-write register state.

Reset
REQ-034 rst asserted: pointers, level, overflow, irq_en, read_data and irq all go to 0, and threshold goes to 1.
REQ-035 rst mid-operation discards all frames immediately; storage contents need not be cleared.
REQ-036 The first push is accepted on the first clk edge after rst deasserts.

Structure
REQ-037 Package audio_fifo_pkg SHALL hold the register address constants, STATUS/CTRL bit positions and the CTRL struct typedef.
REQ-038 Storage and pointers SHALL sit in the sub-module frame_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, head, level), and the top SHALL hold the register decode and irq logic.

Verification
REQ-039 Defaults: push 3 frames (L=0x000011, R=0x000022 ...) -> STATUS level=3; HEAD[0]=0x11, HEAD[1]=0x22; POP returns 1; level=2.
REQ-040 Push 17 frames, no pops -> level=16, full=1, overflow=1; the 17th frame is absent; after 16 POPs, a 17th POP returns 0.
REQ-041 CTRL=0x8000_0004, push 4 frames -> irq rises the cycle after the 4th push; one POP -> irq low one cycle later.
REQ-042 When full, drive in_ready with a POP read in the same cycle -> level stays 16, overflow=0, and the frame order is preserved across wrap.
REQ-043 Assert rst asynchronously mid-burst (level=9, irq=1) -> irq=0 and level=0 immediately; CTRL reads 0x0000_0001.
REQ-044 CLEAR=0x3 while full and overflowed -> next STATUS read gives 0x0001_0000 (empty=1, overflow=0).
